ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Shares the single-port data `ram` between two requesters.
- M0 is the `cpu` data port (MEM_ADDR / WRITE_MEM_EN / WRITE_MEM_DATA / READ_MEM_DATA).
- M1 is a secondary master (loader, DMA or debug).
- Sits between the requesters and `ram`. Grants at most one access per cycle, M0 favoured, bounded M1 starvation. Routes synchronous read data back to the issuing master.

Parameters:
- WIDTH, 32, address and data width (matches cpu/ram).
- MAX_WAIT, 4, max consecutive cycles M1 may be denied while requesting before it is forced a grant (>=1).
- RD_LATENCY, 1, ram read latency in cycles (>=1).

Ports:
- CLK  in  1  clock; all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- M0_REQ  in  1  M0 access request.
- M0_WE  in  1  M0 write (1) / read (0).
- M0_ADDR  in  WIDTH  M0 address.
- M0_WD  in  WIDTH  M0 write data.
- M0_GNT  out  1  M0 access issued this cycle.
- M0_RVALID  out  1  M0 read data valid.
- M0_RD  out  WIDTH  M0 read data.
- M1_REQ, M1_WE, M1_ADDR, M1_WD, M1_GNT, M1_RVALID, M1_RD: same as M0 for M1.
- MEM_ADDR  out  WIDTH  ram address.
- WRITE_MEM_EN  out  1  ram write enable.
- WRITE_MEM_DATA  out  WIDTH  ram write data.
- READ_MEM_DATA  in  WIDTH  ram read data.

Behaviour:
- Handshake:
  - Master holds REQ/WE/ADDR/WD stable until it sees GNT high.
  - GNT is combinational from current REQs and registered state.
  - Access is performed in the GNT cycle. REQ may remain high for back-to-back accesses.
- Grant rule, per cycle:
  - Neither requests: no grant.
  - One requests: grant it.
  - Both request: grant M1 iff wait_cnt == MAX_WAIT, else M0.
- wait_cnt (width $clog2(MAX_WAIT+1)):
  - Increments each cycle M1_REQ=1 and M1 is denied.
  - Clears when M1 is granted or M1_REQ=0.
  - Never exceeds MAX_WAIT.
- FSM state `last` (registered; observable for debug): IDLE / OWN_M0 / OWN_M1 = grantee of previous cycle. Next state = this cycle's grantee, or IDLE if none.
- RAM mux:
  - Granted master's ADDR/WD drive MEM_ADDR/WRITE_MEM_DATA.
  - WRITE_MEM_EN = granted WE.
  - No grant: MEM_ADDR=0, WRITE_MEM_DATA=0, WRITE_MEM_EN=0.
- Read return:
  - Each granted read pushes {valid, owner} into an RD_LATENCY-deep shift pipe.
  - At pipe output, owner's RVALID pulses 1 cycle. Both Mx_RD = READ_MEM_DATA.
  - Writes produce no RVALID.
  - Back-to-back reads from alternating masters return in issue order, one per cycle.
- Same-address M0 write and M1 read in consecutive cycles: executed strictly in grant order, no forwarding.
- Reset (RESET low, any time, including mid-operation):
  - All GNT/RVALID/WRITE_MEM_EN = 0; MEM_ADDR/WRITE_MEM_DATA = 0.
  - last = IDLE, wait_cnt = 0, return pipe cleared.
  - In-flight reads are dropped, never returned.
  - REQs are ignored while RESET low. First grant possible in the first cycle after RESET deasserts.

Optional Feature:
- Macro: RAM_ARBITER_STATS_EN.
- Defined: adds outputs M0_GNT_CNT, M1_GNT_CNT, CONFLICT_CNT (16 bits each, saturating at 16'hFFFF, reset to 0).
  - CONFLICT_CNT counts cycles with both REQs high.
  - Counters are observe-only and never affect arbitration.
- Undefined: ports and logic absent; arbitration behaviour identical.

Decomposition:
- Package ram_arbiter_pkg:
  - master_e {M0, M1}.
  - arb_state_e {IDLE, OWN_M0, OWN_M1}.
  - STATS_W = 16.
- Sub-module rd_return_pipe: parameter RD_LATENCY; shift register of {valid, owner}; async active-low clear.

Test Plan:
- M0 read addr 0x10 (ram[0x10]=0xDEADBEEF), M1 idle -> M0_GNT same cycle; M0_RVALID 1 cycle later with M0_RD=0xDEADBEEF; M1_RVALID stays 0.
- Both REQ held continuously, MAX_WAIT=4 -> grant sequence M0,M0,M0,M0,M1, repeating; M1 never waits more than 4 cycles.
- M0 write 0x55 to 0x20, M1 read 0x20 requested same cycle -> M0 granted first; M1 read next cycle returns 0x55.
- M1 read, then M0 read back-to-back -> M1_RVALID then M0_RVALID on consecutive cycles, each with its own data, no cross-delivery.
- RESET low on cycle after an M1 read grant -> M1_RVALID never asserts; all outputs 0; after release, M0 single request is granted in the first cycle.
- With RAM_ARBITER_STATS_EN, 10 conflict cycles -> CONFLICT_CNT=10, M0_GNT_CNT=8, M1_GNT_CNT=2 (MAX_WAIT=4).

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the ram_arbiter slice: master ids, arbiter state and stats width.
package ram_arbiter_pkg;

   typedef enum logic {M0, M1} master_e;

   typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1} arb_state_e;

   localparam int unsigned STATS_W = 16;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester/ram bus of ram_arbiter; slave = arbiter view, master = requester/ram view.
// Stats counters exist only when RAM_ARBITER_STATS_EN is defined.
interface ram_arbiter_if
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) ();

   logic             M0_REQ;
   logic             M0_WE;
   logic [WIDTH-1:0] M0_ADDR;
   logic [WIDTH-1:0] M0_WD;
   logic             M0_GNT;
   logic             M0_RVALID;
   logic [WIDTH-1:0] M0_RD;

   logic             M1_REQ;
   logic             M1_WE;
   logic [WIDTH-1:0] M1_ADDR;
   logic [WIDTH-1:0] M1_WD;
   logic             M1_GNT;
   logic             M1_RVALID;
   logic [WIDTH-1:0] M1_RD;

   logic [WIDTH-1:0] MEM_ADDR;
   logic             WRITE_MEM_EN;
   logic [WIDTH-1:0] WRITE_MEM_DATA;
   logic [WIDTH-1:0] READ_MEM_DATA;

   arb_state_e       LAST;

`ifdef RAM_ARBITER_STATS_EN
   logic [STATS_W-1:0] M0_GNT_CNT;
   logic [STATS_W-1:0] M1_GNT_CNT;
   logic [STATS_W-1:0] CONFLICT_CNT;
`endif

   modport slave (
      input  M0_REQ, M0_WE, M0_ADDR, M0_WD,
      output M0_GNT, M0_RVALID, M0_RD,
      input  M1_REQ, M1_WE, M1_ADDR, M1_WD,
      output M1_GNT, M1_RVALID, M1_RD,
      output MEM_ADDR, WRITE_MEM_EN, WRITE_MEM_DATA,
      input  READ_MEM_DATA,
      output LAST
`ifdef RAM_ARBITER_STATS_EN
      , output M0_GNT_CNT, M1_GNT_CNT, CONFLICT_CNT
`endif
   );

   modport master (
      output M0_REQ, M0_WE, M0_ADDR, M0_WD,
      input  M0_GNT, M0_RVALID, M0_RD,
      output M1_REQ, M1_WE, M1_ADDR, M1_WD,
      input  M1_GNT, M1_RVALID, M1_RD,
      input  MEM_ADDR, WRITE_MEM_EN, WRITE_MEM_DATA,
      output READ_MEM_DATA,
      input  LAST
`ifdef RAM_ARBITER_STATS_EN
      , input M0_GNT_CNT, M1_GNT_CNT, CONFLICT_CNT
`endif
   );

endinterface

// File: rtl/ram_arbiter_rd_return_pipe.sv
// Shift pipe of {valid, owner} tags that tracks ram reads until their data returns.
module rd_return_pipe
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  logic    push_valid_i,
   input  master_e push_owner_i,
   output logic    pop_valid_o,
   output master_e pop_owner_o
);

   logic [RD_LATENCY-1:0] valid_q;
   master_e               owner_q [RD_LATENCY];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < RD_LATENCY; i++) owner_q[i] <= M0;
      end else begin
         valid_q[0] <= push_valid_i;
         owner_q[0] <= push_owner_i;
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
            owner_q[i] <= owner_q[i-1];
         end
      end
   end

   assign pop_valid_o = valid_q[RD_LATENCY-1];
   assign pop_owner_o = owner_q[RD_LATENCY-1];

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single-port data ram: M0 favoured, M1 forced after MAX_WAIT denials.
// Optional grant/conflict counters under RAM_ARBITER_STATS_EN.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned MAX_WAIT   = 4,
   parameter int unsigned RD_LATENCY = 1
) (
   input logic          CLK,
   input logic          RESET,
   ram_arbiter_if.slave bus
);

   localparam int unsigned WW = $clog2(MAX_WAIT + 1);

   logic [WW-1:0] wait_q, wait_d;
   arb_state_e    last_q, last_d;
   logic          gnt0, gnt1;
   logic          push_valid;
   master_e       push_owner;
   logic          pop_valid;
   master_e       pop_owner;

   // Grants are gated by RESET so requests are ignored while it is held low.
   always_comb begin
      gnt1 = RESET & bus.M1_REQ & (~bus.M0_REQ | (wait_q == WW'(MAX_WAIT)));
      gnt0 = RESET & bus.M0_REQ & ~gnt1;

      wait_d = '0;
      if (bus.M1_REQ && !gnt1)
         wait_d = (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + WW'(1);

      last_d = gnt0 ? OWN_M0 : (gnt1 ? OWN_M1 : IDLE);

      push_valid = (gnt0 & ~bus.M0_WE) | (gnt1 & ~bus.M1_WE);
      push_owner = gnt1 ? M1 : M0;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wait_q <= '0;
         last_q <= IDLE;
      end else begin
         wait_q <= wait_d;
         last_q <= last_d;
      end
   end

   always_comb begin
      bus.MEM_ADDR       = '0;
      bus.WRITE_MEM_DATA = '0;
      bus.WRITE_MEM_EN   = 1'b0;
      if (gnt1) begin
         bus.MEM_ADDR       = bus.M1_ADDR;
         bus.WRITE_MEM_DATA = bus.M1_WD;
         bus.WRITE_MEM_EN   = bus.M1_WE;
      end else if (gnt0) begin
         bus.MEM_ADDR       = bus.M0_ADDR;
         bus.WRITE_MEM_DATA = bus.M0_WD;
         bus.WRITE_MEM_EN   = bus.M0_WE;
      end
   end

   rd_return_pipe #(
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_return_pipe (
      .clk_i        (CLK),
      .rst_ni       (RESET),
      .push_valid_i (push_valid),
      .push_owner_i (push_owner),
      .pop_valid_o  (pop_valid),
      .pop_owner_o  (pop_owner)
   );

   assign bus.M0_GNT    = gnt0;
   assign bus.M1_GNT    = gnt1;
   assign bus.M0_RVALID = pop_valid & (pop_owner == M0);
   assign bus.M1_RVALID = pop_valid & (pop_owner == M1);
   assign bus.M0_RD     = bus.READ_MEM_DATA;
   assign bus.M1_RD     = bus.READ_MEM_DATA;
   assign bus.LAST      = last_q;

`ifdef RAM_ARBITER_STATS_EN
   logic [STATS_W-1:0] m0_cnt_q, m1_cnt_q, conf_cnt_q;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         m0_cnt_q   <= '0;
         m1_cnt_q   <= '0;
         conf_cnt_q <= '0;
      end else begin
         if (gnt0 && m0_cnt_q != '1) m0_cnt_q <= m0_cnt_q + STATS_W'(1);
         if (gnt1 && m1_cnt_q != '1) m1_cnt_q <= m1_cnt_q + STATS_W'(1);
         if (bus.M0_REQ && bus.M1_REQ && conf_cnt_q != '1)
            conf_cnt_q <= conf_cnt_q + STATS_W'(1);
      end
   end

   assign bus.M0_GNT_CNT   = m0_cnt_q;
   assign bus.M1_GNT_CNT   = m1_cnt_q;
   assign bus.CONFLICT_CNT = conf_cnt_q;
`endif

endmodule
